// File: rtl/prog_ctr_pkg.sv
// prog_pkg: shared types and constants for the program-counter / run-control stage.
package prog_pkg;

    // Run-control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Default PC width.
    localparam int PC_W_DEF = 8;

    // Highest instruction address at the default width; incrementing past it is a fault.
    localparam logic [PC_W_DEF-1:0] PC_MAX = {PC_W_DEF{1'b1}};

endpackage

// File: rtl/prog_ctr_if.sv
// prog_ctr_if: run-control and PC signals between the core and prog_ctr.
// The CycleCount output exists only when CYCLE_CTR_EN is defined.
interface prog_ctr_if #(
    parameter int PC_W = 8
) ();
    logic            Start;
    logic            Stall;
    logic            Halt;
    logic            BranchTaken;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] PC;
    logic            Running;
    logic            Done;
    logic            Fault;
`ifdef CYCLE_CTR_EN
    logic [15:0]     CycleCount;
`endif

`ifdef CYCLE_CTR_EN
    modport master (
        output Start, Stall, Halt, BranchTaken, Target,
        input  PC, Running, Done, Fault, CycleCount
    );
    modport slave (
        input  Start, Stall, Halt, BranchTaken, Target,
        output PC, Running, Done, Fault, CycleCount
    );
`else
    modport master (
        output Start, Stall, Halt, BranchTaken, Target,
        input  PC, Running, Done, Fault
    );
    modport slave (
        input  Start, Stall, Halt, BranchTaken, Target,
        output PC, Running, Done, Fault
    );
`endif
endinterface

// File: rtl/prog_ctr_cycle_ctr.sv
// cycle_ctr: saturating 16-bit counter with synchronous clear and enable.
// Only compiled when CYCLE_CTR_EN is defined.
`ifdef CYCLE_CTR_EN
module cycle_ctr (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [15:0] o_count
);
    logic [15:0] r_count;

    // Count enabled cycles; clear has priority, and the count sticks at all-ones.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= 16'h0000;
        end else if (i_clr) begin
            r_count <= 16'h0000;
        end else if (i_en && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'h0001;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
endmodule
`endif

// File: rtl/prog_ctr.sv
// prog_ctr: program counter and run-control FSM (IDLE -> RUN -> DONE).
// Optional feature: define CYCLE_CTR_EN to add a saturating RUN-cycle counter
// on bus.CycleCount.
module prog_ctr
    import prog_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic       Clk,
    input  logic       Reset,
    prog_ctr_if.slave  bus
);
    localparam logic [PC_W-1:0] L_PC_MAX = {PC_W{1'b1}};
    localparam logic [PC_W-1:0] L_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    pc_state_t       r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_fault;
    logic            r_running;
    logic            r_done;

    pc_state_t       w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_fault_nxt;
    logic            w_ctr_clr;
    logic            w_ctr_en;

    // Next-state / next-PC selection; RUN follows Start > Stall > Halt > Branch > increment.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_ctr_clr   = 1'b0;
        w_ctr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_ADDR;
                    w_fault_nxt = 1'b0;
                    w_ctr_clr   = 1'b1;
                end else begin
                    w_pc_nxt    = START_ADDR;
                end
            end
            RUN: begin
                // Every RUN cycle counts, stalled ones included.
                w_ctr_en = 1'b1;
                if (bus.Start) begin
                    w_pc_nxt  = START_ADDR;
                    w_ctr_clr = 1'b1;
                end else if (bus.Stall) begin
                    w_pc_nxt = r_pc;
                end else if (bus.Halt) begin
                    w_state_nxt = DONE;
                end else if (bus.BranchTaken) begin
                    // Absolute target; a branch from the top address is legal.
                    w_pc_nxt = bus.Target;
                end else if (r_pc == L_PC_MAX) begin
                    // Falling off the end of memory: stop rather than wrap to 0.
                    w_fault_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_pc_nxt = r_pc + L_PC_ONE;
                end
            end
            DONE: begin
                if (bus.Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_ADDR;
                    w_fault_nxt = 1'b0;
                    w_ctr_clr   = 1'b1;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = START_ADDR;
                w_fault_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and status flags; Running/Done are registered decodes of the next state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_pc      <= START_ADDR;
            r_fault   <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_fault   <= w_fault_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == DONE);
        end
    end

    assign bus.PC      = r_pc;
    assign bus.Running = r_running;
    assign bus.Done    = r_done;
    assign bus.Fault   = r_fault;

`ifdef CYCLE_CTR_EN
    logic [15:0] w_cycle_count;

    cycle_ctr u_cycle_ctr (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_clr   (w_ctr_clr),
        .i_en    (w_ctr_en),
        .o_count (w_cycle_count)
    );

    assign bus.CycleCount = w_cycle_count;
`else
    logic w_unused_ctr;
    assign w_unused_ctr = ^{w_ctr_clr, w_ctr_en};
`endif
endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program counter and run-control stage for the single-cycle CSE141L core. Holds the instruction address, advances it each cycle, and on a taken branch loads the absolute 8-bit target produced by the branch-target lookup table. It also sequences each program run from Start to Halt.

## Interface
Parameters:
- PC_W, 8, width of PC and of Target
- START_ADDR, 0, address loaded on reset and on every Start

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset; all state clears while Reset=0
- Start  in  1  one-cycle request to begin or restart a program run
- Stall  in  1  freeze PC and state for this cycle
- Halt  in  1  decoded halt instruction at the current PC
- BranchTaken  in  1  decoded branch instruction whose condition is true
- Target  in  PC_W  absolute branch target from the lookup table, valid in the same cycle as BranchTaken
- PC  out  PC_W  current instruction address
- Running  out  1  high in RUN state
- Done  out  1  high in DONE state
- Fault  out  1  sticky flag: PC ran off the end of instruction memory

## Operation
- State machine (prog_pkg::pc_state_t): IDLE, RUN, DONE.
- Reset: state=IDLE, PC=START_ADDR, Running=0, Done=0, Fault=0.
- IDLE: PC holds START_ADDR. Start moves to RUN and leaves PC at START_ADDR. All other inputs are ignored.
- RUN: the following are evaluated once per cycle in priority order:
  1. Start: PC=START_ADDR, stay in RUN (restart).
  2. Stall: hold PC and state.
  3. Halt: go to DONE and hold PC at the halt address.
  4. BranchTaken: PC=Target.
  5. Otherwise PC=PC+1.
- Wrap-around: increment with PC=2^PC_W-1 sets Fault=1, goes to DONE, and holds PC. There is no silent wrap to 0.
- A branch to Target=PC is legal and repeats indefinitely. A branch at the top address is legal and does not raise Fault.
- DONE: Done=1 and PC holds. Start moves to RUN, sets PC=START_ADDR, and clears Fault. Stall, Halt and BranchTaken are ignored.
- Halt together with BranchTaken: Halt wins.
- Running and Done are decoded directly from the state register. They are never both high.

## Timing
- All outputs are registered, and each changes only on a Clk rising edge or on Reset assertion.
- Branch latency is 1 cycle. BranchTaken/Target are sampled at edge N, and PC=Target is visible after edge N.
- Start latency is 1 cycle. Running rises after the edge that samples Start.
- Done rises on the edge that samples Halt, so the halt address remains on PC.
- Start must be a one-cycle pulse. A level-held Start restarts the program every cycle while in RUN.
- Reset asserted mid-run: outputs go to their reset values immediately (asynchronously). The run resumes only on a new Start after Reset is released.

## Configuration
- CYCLE_CTR_EN defined:
  - Adds output CycleCount [15:0].
  - Cleared on reset and on every accepted Start.
  - Increments on every RUN cycle, including stalled cycles.
  - Saturates at 16'hFFFF.
  - Holds its value in DONE so the bench can read the cycle count of the program.
- CYCLE_CTR_EN not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- prog_pkg holds:
  - pc_state_t enum {IDLE, RUN, DONE}
  - localparam PC_W_DEF=8
  - the PC_MAX constant
- The core is one always_ff block for the state and PC, plus a small always_comb block for next-PC selection.
- Natural sub-module: cycle_ctr (saturating 16-bit counter with clear and enable), instantiated only under CYCLE_CTR_EN.

## Test plan
- Reset, then Start pulse, then 5 idle cycles → PC sequence 0,1,2,3,4,5. Running=1 and Done=0 throughout.
- BranchTaken=1 with Target=228 at PC=3 → PC=228 on the next cycle, then 229.
- Halt at PC=10 with BranchTaken=1 and Target=4 asserted in the same cycle → Done=1 and PC stays 10. A further Start gives PC=0 and Running=1.
- Run with no branches until PC=255 → Fault=1, Done=1, PC=255. The next Start clears Fault.
- Stall held for 3 cycles at PC=7 with BranchTaken=1 and Target=128 → PC remains 7, advances to 128 after Stall drops. Reset pulled low mid-run gives PC=0 and Running=0 immediately.
- With CYCLE_CTR_EN defined: Start, then Halt on the 20th RUN cycle → CycleCount=20 held in DONE, cleared to 0 on the next Start.
